// File: rtl/network_arbiter_state_writer.sv
`default_nettype none
// ============================================================================
// Module   : network_arbiter_state_writer
// Brief    : Drains network traffic, commits a trusted/untrusted mode change
//            to the arbiter and confirms it by reading back its state_reg.
// Revision : 1.0 - initial release
// ============================================================================
module network_arbiter_state_writer #(
    parameter int QUIET_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        REQ_VALID,
    input  logic [31:0] REQ_VALUE,
    output logic        REQ_READY,
    input  logic        NET_BUSY,
    output logic        FLUSH,
    output logic [31:0] WRITE_STATE_VALUE,
    input  logic [31:0] STATE_REG,
    output logic        RSP_VALID,
    output logic [1:0]  RSP_STATUS,
    input  logic        RSP_READY
);

    localparam int                 c_CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_QUIET     = c_CNT_W'(QUIET_CYCLES);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT   = c_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [31:0]        c_TRUSTED   = 32'h0000_0000;
    localparam logic [31:0]        c_UNTRUSTED = 32'hF0F0_F0F0;
    localparam logic [1:0]         c_ST_OK       = 2'b00;
    localparam logic [1:0]         c_ST_ILLEGAL  = 2'b01;
    localparam logic [1:0]         c_ST_TIMEOUT  = 2'b10;
    localparam logic [1:0]         c_ST_MISMATCH = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRAIN  = 3'd1,
        S_COMMIT = 3'd2,
        S_VERIFY = 3'd3,
        S_RSP    = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_pend;
    logic [31:0]        w_pend_nxt;
    logic [31:0]        r_cur;
    logic [31:0]        w_cur_nxt;
    logic [c_CNT_W-1:0] r_quiet_cnt;
    logic [c_CNT_W-1:0] w_quiet_nxt;
    logic [c_CNT_W-1:0] w_quiet_inc;
    logic [c_CNT_W-1:0] r_to_cnt;
    logic [c_CNT_W-1:0] w_to_nxt;
    logic [c_CNT_W-1:0] w_to_inc;
    logic               r_req_ready;
    logic               r_flush;
    logic               w_flush_nxt;
    logic               r_rsp_valid;
    logic [1:0]         r_rsp_status;
    logic [1:0]         w_rsp_status_nxt;
    logic               w_pend_legal;

    assign w_pend_legal = (r_pend == c_TRUSTED) || (r_pend == c_UNTRUSTED);
    assign w_quiet_inc  = NET_BUSY ? '0 : (r_quiet_cnt + c_CNT_ONE);
    assign w_to_inc     = r_to_cnt + c_CNT_ONE;

    always_comb begin
        w_state_nxt      = r_state;
        w_pend_nxt       = r_pend;
        w_cur_nxt        = r_cur;
        w_quiet_nxt      = r_quiet_cnt;
        w_to_nxt         = r_to_cnt;
        w_rsp_status_nxt = r_rsp_status;

        case (r_state)
            S_IDLE: begin
                if (r_req_ready && REQ_VALID) begin
                    w_pend_nxt  = REQ_VALUE;
                    w_quiet_nxt = '0;
                    w_to_nxt    = '0;
                    w_state_nxt = S_DRAIN;
                end
            end
            // The latched request is classified on the first DRAIN cycle;
            // rejected and no-op requests leave before FLUSH is ever raised.
            S_DRAIN: begin
                if (!w_pend_legal) begin
                    w_rsp_status_nxt = c_ST_ILLEGAL;
                    w_state_nxt      = S_RSP;
                end else if (r_pend == r_cur) begin
                    w_rsp_status_nxt = c_ST_OK;
                    w_state_nxt      = S_RSP;
                end else begin
                    w_quiet_nxt = w_quiet_inc;
                    w_to_nxt    = w_to_inc;
                    if (w_quiet_inc == c_QUIET) begin
                        w_cur_nxt   = r_pend;
                        w_state_nxt = S_COMMIT;
                    end else if (w_to_inc == c_TIMEOUT) begin
                        w_rsp_status_nxt = c_ST_TIMEOUT;
                        w_state_nxt      = S_RSP;
                    end
                end
            end
            S_COMMIT: begin
                w_state_nxt = S_VERIFY;
            end
            S_VERIFY: begin
                w_rsp_status_nxt = (STATE_REG == r_cur) ? c_ST_OK : c_ST_MISMATCH;
                w_state_nxt      = S_RSP;
            end
            S_RSP: begin
                if (RSP_READY) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_flush_nxt = ((r_state == S_DRAIN) && (w_state_nxt == S_DRAIN)) ||
                      (w_state_nxt == S_COMMIT) || (w_state_nxt == S_VERIFY);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state      <= S_IDLE;
            r_pend       <= c_TRUSTED;
            r_cur        <= c_TRUSTED;
            r_quiet_cnt  <= '0;
            r_to_cnt     <= '0;
            r_req_ready  <= 1'b0;
            r_flush      <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_status <= c_ST_OK;
        end else begin
            r_state      <= w_state_nxt;
            r_pend       <= w_pend_nxt;
            r_cur        <= w_cur_nxt;
            r_quiet_cnt  <= w_quiet_nxt;
            r_to_cnt     <= w_to_nxt;
            r_req_ready  <= (w_state_nxt == S_IDLE);
            r_flush      <= w_flush_nxt;
            r_rsp_valid  <= (w_state_nxt == S_RSP);
            r_rsp_status <= w_rsp_status_nxt;
        end
    end

    assign REQ_READY         = r_req_ready;
    assign FLUSH             = r_flush;
    assign WRITE_STATE_VALUE = r_cur;
    assign RSP_VALID         = r_rsp_valid;
    assign RSP_STATUS        = r_rsp_status;

endmodule
`default_nettype wire

// File: tb/tb_network_arbiter_state_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_network_arbiter_state_writer
// Brief    : Vector table, reset corner cases and randomized requests checked
//            against a cycle-count model of the state writer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_network_arbiter_state_writer;

    localparam int          Q         = 4;
    localparam int          T         = 1024;
    localparam logic [31:0] TRUSTED   = 32'h0000_0000;
    localparam logic [31:0] UNTRUSTED = 32'hF0F0_F0F0;

    logic        CLK       = 1'b0;
    logic        RESETN    = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic [31:0] REQ_VALUE = 32'h0;
    logic        NET_BUSY  = 1'b0;
    logic        RSP_READY = 1'b0;
    logic        REQ_READY;
    logic        FLUSH;
    logic [31:0] WRITE_STATE_VALUE;
    logic [31:0] STATE_REG;
    logic        RSP_VALID;
    logic [1:0]  RSP_STATUS;

    logic        sr_zero   = 1'b0;
    logic [31:0] arb_reg;
    logic [31:0] model_cur = 32'h0;
    bit          busy_arr [0:2047];
    int          n_checks  = 0;
    int          n_errors  = 0;

    typedef struct {
        logic [31:0] value;
        int          hold;
        logic [15:0] bits;
        int          len;
        bit          tail;
        bit          srz;
        int          rdly;
        bit          early;
        logic [1:0]  exp_st;
        int          exp_lat;
        logic [31:0] exp_wsv;
    } vec_t;

    vec_t tbl [12];

    network_arbiter_state_writer #(
        .QUIET_CYCLES   (Q),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .CLK               (CLK),
        .RESETN            (RESETN),
        .REQ_VALID         (REQ_VALID),
        .REQ_VALUE         (REQ_VALUE),
        .REQ_READY         (REQ_READY),
        .NET_BUSY          (NET_BUSY),
        .FLUSH             (FLUSH),
        .WRITE_STATE_VALUE (WRITE_STATE_VALUE),
        .STATE_REG         (STATE_REG),
        .RSP_VALID         (RSP_VALID),
        .RSP_STATUS        (RSP_STATUS),
        .RSP_READY         (RSP_READY)
    );

    always #5 CLK = ~CLK;

    // Arbiter main logic: captures the written value every edge, or is
    // pinned to zero to provoke a read-back mismatch.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) arb_reg <= 32'h0;
        else         arb_reg <= sr_zero ? 32'h0 : WRITE_STATE_VALUE;
    end
    assign STATE_REG = arb_reg;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill_busy(input int hold, input logic [15:0] bits, input int len, input bit tail);
        for (int k = 0; k < 2048; k++) begin
            if (k == 0)                 busy_arr[k] = 1'b0;
            else if (k <= hold)         busy_arr[k] = 1'b1;
            else if (k - hold <= len)   busy_arr[k] = bits[4'(k - hold - 1)];
            else                        busy_arr[k] = tail;
        end
    endtask

    // Outcome of one request from the rules: status, cycles from accept to
    // RSP_VALID, and the value left on the write bus.
    function automatic void model(input logic [31:0] v, input logic [31:0] cur, input bit srz,
                                  output logic [1:0] st, output int lat, output logic [31:0] nc);
        int run;
        bit done;
        st  = 2'b01;
        lat = 1;
        nc  = cur;
        if (v != TRUSTED && v != UNTRUSTED) begin
            st = 2'b01;
        end else if (v == cur) begin
            st = 2'b00;
        end else begin
            run  = 0;
            done = 1'b0;
            for (int k = 1; k <= T && !done; k++) begin
                run = busy_arr[k] ? 0 : run + 1;
                if (run == Q) begin
                    done = 1'b1;
                    nc   = v;
                    lat  = k + 2;
                    st   = (((srz ? TRUSTED : v) == v) ? 2'b00 : 2'b11);
                end else if (k == T) begin
                    done = 1'b1;
                    lat  = T;
                    st   = 2'b10;
                end
            end
        end
    endfunction

    task automatic wait_ready(input string tag);
        int w = 0;
        while (REQ_READY !== 1'b1 && w < 20) begin
            @(negedge CLK);
            w++;
        end
        chk({tag, "_req_ready_idle"}, 32'(REQ_READY), 32'd1);
    endtask

    task automatic run_req(input logic [31:0] v, input bit srz, input int rdly, input bit early,
                           input logic [1:0] exp_st, input int exp_lat, input logic [31:0] exp_wsv);
        logic [31:0] old     = model_cur;
        bit          commits = (exp_lat > 1) && (exp_st != 2'b10);
        wait_ready("req");
        if (REQ_READY !== 1'b1) return;
        sr_zero   = srz;
        REQ_VALID = 1'b1;
        REQ_VALUE = v;
        NET_BUSY  = busy_arr[1];
        RSP_READY = early;
        @(posedge CLK);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        REQ_VALUE = $urandom;
        chk("req_ready_after_accept", 32'(REQ_READY), 32'd0);
        for (int k = 1; k <= exp_lat; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            NET_BUSY = busy_arr[k + 1];
            chk("flush", 32'(FLUSH), 32'(k < exp_lat));
            chk("rsp_valid", 32'(RSP_VALID), 32'(k == exp_lat));
            chk("write_state_value", WRITE_STATE_VALUE, (commits && k >= exp_lat - 2) ? v : old);
        end
        chk("rsp_status", 32'(RSP_STATUS), 32'(exp_st));
        chk("final_write_state_value", WRITE_STATE_VALUE, exp_wsv);
        NET_BUSY = 1'b0;
        if (!early) begin
            for (int d = 0; d < rdly; d++) begin
                @(posedge CLK);
                @(negedge CLK);
                chk("rsp_valid_held", 32'(RSP_VALID), 32'd1);
                chk("rsp_status_held", 32'(RSP_STATUS), 32'(exp_st));
            end
            RSP_READY = 1'b1;
        end
        @(posedge CLK);
        @(negedge CLK);
        chk("rsp_valid_after_handshake", 32'(RSP_VALID), 32'd0);
        chk("req_ready_after_handshake", 32'(REQ_READY), 32'd1);
        RSP_READY = 1'b0;
        sr_zero   = 1'b0;
        model_cur = exp_wsv;
    endtask

    task automatic reset_mid(input logic [31:0] v, input bit busy, input int kstop);
        for (int k = 0; k < 2048; k++) busy_arr[k] = (k > 0) && busy;
        wait_ready("rst");
        REQ_VALID = 1'b1;
        REQ_VALUE = v;
        NET_BUSY  = busy;
        @(posedge CLK);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        for (int k = 1; k <= kstop; k++) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        chk("pre_reset_wsv", WRITE_STATE_VALUE, (!busy && kstop >= Q) ? v : model_cur);
        chk("pre_reset_flush", 32'(FLUSH), 32'd1);
        RESETN = 1'b0;
        #1;
        chk("async_reset_flush", 32'(FLUSH), 32'd0);
        chk("async_reset_wsv", WRITE_STATE_VALUE, 32'h0);
        chk("async_reset_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("async_reset_req_ready", 32'(REQ_READY), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RESETN   = 1'b1;
        NET_BUSY = 1'b0;
        chk("req_ready_before_first_edge", 32'(REQ_READY), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            chk("req_ready_after_release", 32'(REQ_READY), 32'd1);
            chk("no_rsp_after_reset", 32'(RSP_VALID), 32'd0);
            chk("no_flush_after_reset", 32'(FLUSH), 32'd0);
        end
        model_cur = 32'h0;
    endtask

    initial begin
        logic [1:0]  st;
        int          lat;
        logic [31:0] nc;
        logic [31:0] v;
        int          pct;
        int          r;
        bit          srz;

        tbl[0]  = '{UNTRUSTED,     0,    16'h0,    0, 1'b0, 1'b0, 0, 1'b0, 2'b00, 6,    UNTRUSTED};
        tbl[1]  = '{32'h1234_5678, 0,    16'h0,    0, 1'b0, 1'b0, 2, 1'b0, 2'b01, 1,    UNTRUSTED};
        tbl[2]  = '{UNTRUSTED,     0,    16'h0,    0, 1'b0, 1'b0, 1, 1'b1, 2'b00, 1,    UNTRUSTED};
        tbl[3]  = '{TRUSTED,       0,    16'h0,    0, 1'b0, 1'b0, 0, 1'b1, 2'b00, 6,    TRUSTED};
        tbl[4]  = '{UNTRUSTED,     0,    16'h0009, 8, 1'b0, 1'b0, 3, 1'b0, 2'b00, 10,   UNTRUSTED};
        tbl[5]  = '{TRUSTED,       2000, 16'h0,    0, 1'b0, 1'b0, 0, 1'b0, 2'b10, 1024, UNTRUSTED};
        tbl[6]  = '{TRUSTED,       1021, 16'h0,    0, 1'b0, 1'b0, 1, 1'b0, 2'b10, 1024, UNTRUSTED};
        tbl[7]  = '{TRUSTED,       1020, 16'h0,    0, 1'b0, 1'b0, 0, 1'b0, 2'b00, 1026, TRUSTED};
        tbl[8]  = '{UNTRUSTED,     0,    16'h0,    0, 1'b0, 1'b1, 1, 1'b0, 2'b11, 6,    UNTRUSTED};
        tbl[9]  = '{UNTRUSTED,     0,    16'h0,    0, 1'b0, 1'b0, 0, 1'b0, 2'b00, 1,    UNTRUSTED};
        tbl[10] = '{TRUSTED,       0,    16'h0,    0, 1'b0, 1'b1, 0, 1'b0, 2'b00, 6,    TRUSTED};
        tbl[11] = '{32'hFFFF_FFFF, 0,    16'h0,    0, 1'b0, 1'b0, 2, 1'b1, 2'b01, 1,    TRUSTED};

        #2 RESETN = 1'b0;
        @(negedge CLK);
        chk("reset_req_ready", 32'(REQ_READY), 32'd0);
        chk("reset_flush", 32'(FLUSH), 32'd0);
        chk("reset_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("reset_rsp_status", 32'(RSP_STATUS), 32'd0);
        chk("reset_wsv", WRITE_STATE_VALUE, 32'h0);
        @(negedge CLK);
        RESETN = 1'b1;
        chk("req_ready_held_low", 32'(REQ_READY), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        chk("req_ready_first_edge", 32'(REQ_READY), 32'd1);

        for (int i = 0; i < 12; i++) begin
            fill_busy(tbl[i].hold, tbl[i].bits, tbl[i].len, tbl[i].tail);
            run_req(tbl[i].value, tbl[i].srz, tbl[i].rdly, tbl[i].early,
                    tbl[i].exp_st, tbl[i].exp_lat, tbl[i].exp_wsv);
        end

        // Reset while VERIFY holds a freshly committed UNTRUSTED value.
        reset_mid(UNTRUSTED, 1'b0, Q + 1);
        fill_busy(0, 16'h0, 0, 1'b0);
        model(UNTRUSTED, model_cur, 1'b0, st, lat, nc);
        run_req(UNTRUSTED, 1'b0, 0, 1'b0, st, lat, nc);
        // Reset in the middle of a busy drain back to TRUSTED.
        reset_mid(TRUSTED, 1'b1, 5);

        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)      v = TRUSTED;
            else if (r < 8) v = UNTRUSTED;
            else            v = $urandom;
            r = int'($urandom_range(0, 19));
            if (r == 0)       pct = 100;
            else if (r < 8)   pct = 0;
            else if (r < 14)  pct = 20;
            else              pct = 50;
            busy_arr[0] = 1'b0;
            for (int k = 1; k < 2048; k++) busy_arr[k] = (int'($urandom_range(0, 99)) < pct);
            srz = ($urandom_range(0, 7) == 0);
            model(v, model_cur, srz, st, lat, nc);
            run_req(v, srz, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), st, lat, nc);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
